// File: rtl/weight_bram_stream_reader.sv
// Purpose: sweeps a preloaded single-port weight BRAM from address 0 to DEPTH-1 and streams each word out over valid/ready.
// Latency: the first w_valid comes 2 cycles after the edge that accepts start; after that, one word per cycle while w_ready=1.
// Backpressure: a 2-entry skid buffer with read credits, so mem_en stays low when the buffer plus the in-flight read would exceed 2.
//
// Ports:
//   clk, rst_n            clock (posedge) and async active-low reset
//   start / busy / done   sweep control: start is sampled in IDLE; done is a one-cycle pulse at the end
//   mem_addr/en/we/di/do  BRAM read port; the BRAM presents mem_do on the negedge after a read issues
//   w_data/index/last     streamed weight, its source address, and an end-of-sweep flag
//   w_valid / w_ready     stream handshake
module weight_bram_stream_reader #(
    parameter int DEPTH  = 28,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_di,
    input  logic [DATA_W-1:0] mem_do,
    output logic [DATA_W-1:0] w_data,
    output logic [ADDR_W-1:0] w_index,
    output logic              w_last,
    output logic              w_valid,
    input  logic              w_ready
);

    if (DEPTH > (1 << ADDR_W)) begin : g_depth_check
        $error("weight_bram_stream_reader: DEPTH does not fit in ADDR_W address bits");
    end

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [1:0]        occ;
    logic [DATA_W-1:0] dat0, dat1;
    logic [ADDR_W-1:0] idx0, idx1;
    logic              pop;
    logic              push;
    logic              issue;
    logic [2:0]        credit_use;

    // The memory is read-only from this block.
    assign mem_we = 1'b0;
    assign mem_di = '0;

    assign w_valid = (occ != 2'd0);
    assign w_data  = dat0;
    assign w_index = idx0;
    assign w_last  = w_valid && (idx0 == LAST_IDX);

    assign pop  = w_valid && w_ready;
    // A read registered at the previous edge has data on mem_do now.
    assign push = mem_en;

    // The number of slots still spoken for after this edge: stored words, plus the word landing now, minus the word leaving.
    assign credit_use = {1'b0, occ} + {2'b00, mem_en} - {2'b00, pop};
    assign issue      = (state == S_FETCH) && (credit_use < 3'd2);

    // Sweep control and read issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ptr      <= '0;
            mem_addr <= '0;
            mem_en   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                        ptr   <= '0;
                    end
                end
                S_FETCH: begin
                    if (issue) begin
                        mem_en   <= 1'b1;
                        mem_addr <= ptr;
                        ptr      <= ptr + 1'b1;
                        if (ptr == LAST_IDX) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && w_last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Two-slot skid buffer. Slot 0 is always the head. Credits guarantee that no push arrives while both slots are full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ  <= 2'd0;
            dat0 <= '0;
            dat1 <= '0;
            idx0 <= '0;
            idx1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        dat0 <= mem_do;
                        idx0 <= mem_addr;
                    end else begin
                        dat1 <= mem_do;
                        idx1 <= mem_addr;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    dat0 <= dat1;
                    idx0 <= idx1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        dat0 <= mem_do;
                        idx0 <= mem_addr;
                    end else begin
                        dat0 <= dat1;
                        idx0 <= idx1;
                        dat1 <= mem_do;
                        idx1 <= mem_addr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
